// File: rtl/mem_responder_if.sv
// Request/response bus between the memory test initiator and mem_responder.
interface mem_responder_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
) ();
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              rvalid;
   logic              ready;
   logic              err;

   modport master (
      output read, write, addr, data_in,
      input  data_out, rvalid, ready, err
   );

   modport slave (
      input  read, write, addr, data_in,
      output data_out, rvalid, ready, err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-beat read/write memory responder with self-clearing init and programmable read wait.
// Optional access counters are enabled with `define MEM_ACCESS_STATS_EN.
module mem_responder #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RD_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
`ifdef MEM_ACCESS_STATS_EN
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
`endif
   mem_responder_if.slave bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD_WAIT, ST_RESP} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic [ADDR_W-1:0]   raddr, raddr_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DATA_W-1:0]   data_out_nxt;
   logic                rvalid_nxt;
   logic                ready_nxt;
   logic                err_nxt;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [DATA_W-1:0]   mem_wd;
   logic                rd_acc;
   logic                wr_acc;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Next-state, memory write port and next values of the registered outputs
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      raddr_nxt    = raddr;
      cnt_nxt      = cnt;
      data_out_nxt = bus.data_out;
      rvalid_nxt   = 1'b0;
      err_nxt      = 1'b0;
      mem_we       = 1'b0;
      mem_wa       = ptr;
      mem_wd       = '0;
      rd_acc       = 1'b0;
      wr_acc       = 1'b0;

      case (state)
         ST_INIT: begin
            mem_we  = 1'b1;
            ptr_nxt = ptr + ADDR_W'(1);
            if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.read && bus.write) begin
               err_nxt = 1'b1;
            end else if (bus.write) begin
               mem_we = 1'b1;
               mem_wa = bus.addr;
               mem_wd = bus.data_in;
               wr_acc = 1'b1;
            end else if (bus.read) begin
               rd_acc    = 1'b1;
               raddr_nxt = bus.addr;
               if (RD_WAIT == 0) begin
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt = ST_RD_WAIT;
                  cnt_nxt   = CNT_W'(RD_WAIT);
               end
            end
         end
         ST_RD_WAIT: begin
            if (cnt == '0) state_nxt = ST_RESP;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         ST_RESP: begin
            data_out_nxt = mem[raddr];
            rvalid_nxt   = 1'b1;
            state_nxt    = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase

      ready_nxt = (state_nxt == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_INIT;
         ptr          <= '0;
         raddr        <= '0;
         cnt          <= '0;
         bus.data_out <= '0;
         bus.rvalid   <= 1'b0;
         bus.ready    <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         state        <= state_nxt;
         ptr          <= ptr_nxt;
         raddr        <= raddr_nxt;
         cnt          <= cnt_nxt;
         bus.data_out <= data_out_nxt;
         bus.rvalid   <= rvalid_nxt;
         bus.ready    <= ready_nxt;
         bus.err      <= err_nxt;
      end
   end

   // Storage has no reset; the INIT sweep clears it instead
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

`ifdef MEM_ACCESS_STATS_EN
   // Saturating counters of accepted reads and writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rd_acc && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
         if (wr_acc && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: init sweep, read/write traffic, illegal requests, mid-read reset.
module tb_mem_responder;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned PERIOD = 10;
   localparam int unsigned EXP_LAT = 3;

   typedef struct {
      logic [DATA_W-1:0] data;
      longint unsigned   t;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rv_count = 0;
   int   spurious = 0;
   exp_t sb[$];

   mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ACCESS_STATS_EN
   logic [15:0] rd_count, wr_count;
   int          exp_rd = 0;
   int          exp_wr = 0;
`endif

   mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(1)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef MEM_ACCESS_STATS_EN
      .rd_count (rd_count),
      .wr_count (wr_count),
`endif
      .bus      (bus.slave)
   );

   always #(PERIOD / 2) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Response monitor: pop the scoreboard on every rvalid
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.rvalid === 1'b1) begin
         rv_count++;
         if (sb.size() == 0) begin
            spurious++;
         end else begin
            e = sb.pop_front();
            check("rdata", 32'(bus.data_out), 32'(e.data));
            check("latency", 32'(($time - 1 - e.t) / PERIOD), EXP_LAT);
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      bus.write = 1'b1; bus.addr = a; bus.data_in = d;
      @(posedge clk);
      #1;
      bus.write = 1'b0;
`ifdef MEM_ACCESS_STATS_EN
      exp_wr++;
`endif
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit push);
      bit   ok;
      exp_t e;
      wait_ready(ok);
      if (!ok) return;
      bus.read = 1'b1; bus.addr = a;
      @(posedge clk);
      e.data = d;
      e.t    = longint'($time);
      if (push) sb.push_back(e);
      #1;
      bus.read = 1'b0;
`ifdef MEM_ACCESS_STATS_EN
      exp_rd++;
`endif
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'(0));
   endtask

   // Counts rising edges from reset release until ready is seen high
   task automatic wait_init(input string tag);
      int n = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(32));
   endtask

   initial begin
      int rv_before;
      bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_in = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready), 32'(0));
      check("rst_rvalid", 32'(bus.rvalid), 32'(0));
      check("rst_err", 32'(bus.err), 32'(0));
      check("rst_dout", 32'(bus.data_out), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      // Requests during init must be ignored
      bus.write = 1'b1; bus.read = 1'b1; bus.addr = 5'd4; bus.data_in = 8'h77;
      wait_init("init_cycles");
      bus.write = 1'b0; bus.read = 1'b0;
      check("init_err", 32'(bus.err), 32'(0));

      for (int a = 0; a < 32; a++) do_read(ADDR_W'(a), 8'h00, 1'b1);
      drain();

      // Read immediately after write to the same address
      do_write(5'd7, 8'hA5);
      do_read(5'd7, 8'hA5, 1'b1);
      @(negedge clk);
      check("ready_drop", 32'(bus.ready), 32'(0));
      drain();

      // Illegal read+write
      rv_before = rv_count;
      @(negedge clk);
      bus.read = 1'b1; bus.write = 1'b1; bus.addr = 5'd3; bus.data_in = 8'hFF;
      @(posedge clk);
      #1;
      bus.read = 1'b0; bus.write = 1'b0;
      check("err_pulse", 32'(bus.err), 32'(1));
      check("err_ready", 32'(bus.ready), 32'(1));
      @(posedge clk);
      #1;
      check("err_one_cycle", 32'(bus.err), 32'(0));
      repeat (4) @(posedge clk);
      #1;
      check("err_no_rvalid", 32'(rv_count), 32'(rv_before));
      do_read(5'd3, 8'h00, 1'b1);
      drain();
`ifdef MEM_ACCESS_STATS_EN
      check("err_rd_count", 32'(rd_count), 32'(exp_rd));
      check("err_wr_count", 32'(wr_count), 32'(exp_wr));
`endif

      for (int a = 0; a < 32; a++) do_write(ADDR_W'(a), DATA_W'(a));
      for (int a = 0; a < 32; a++) do_read(ADDR_W'(a), DATA_W'(a), 1'b1);
      drain();
`ifdef MEM_ACCESS_STATS_EN
      check("rd_count", 32'(rd_count), 32'(exp_rd));
      check("wr_count", 32'(wr_count), 32'(exp_wr));
`endif

      // Reset in the middle of a read wait
      do_write(5'd9, 8'h5A);
      rv_before = rv_count;
      do_read(5'd9, 8'h5A, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(bus.ready), 32'(0));
      check("mid_rst_rvalid", 32'(bus.rvalid), 32'(0));
      check("mid_rst_dout", 32'(bus.data_out), 32'(0));
      check("mid_rst_err", 32'(bus.err), 32'(0));
`ifdef MEM_ACCESS_STATS_EN
      check("mid_rst_rd_count", 32'(rd_count), 32'(0));
      check("mid_rst_wr_count", 32'(wr_count), 32'(0));
      exp_rd = 0;
      exp_wr = 0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_init("reinit_cycles");
      check("mid_rst_no_rvalid", 32'(rv_count), 32'(rv_before));
      do_read(5'd9, 8'h00, 1'b1);
      do_read(5'd31, 8'h00, 1'b1);
      do_read(5'd0, 8'h00, 1'b1);
      drain();

      check("spurious_rvalid", 32'(spurious), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
